intr_context_ctrl: RTL and testbench

- Sits directly downstream of the interrupt device. Consumes its intr_jmp / intr_jmp_addr and drives its intr_en and eret_clear_en inputs.
- Saves the resume PC (EPC) and redirects/flushes the fetch stage to the vector.
- Gates further interrupts while one is in service, and performs the ERET return sequence.
- Registered FSM between the interrupt device and the PC-select logic.

---
 rtl/intr_context_ctrl_pkg.sv | 20 ++
 rtl/intr_context_ctrl_epc.sv | 54 +++++
 rtl/intr_context_ctrl.sv | 150 +++++++++++++++
 tb/tb_intr_context_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_context_ctrl_pkg.sv
// Shared definitions for the interrupt context controller: core address
// width, default vector constant and the controller state encoding.
package intr_context_ctrl_pkg;

    // Instruction-memory word-address width used core-wide.
    localparam int unsigned CORE_IM_ADDR_BIT = 10;

    // Top-of-memory interrupt vector, in words.
    localparam logic [CORE_IM_ADDR_BIT-1:0] INTERRUPT_VECTOR_TOP_DIV4 =
        CORE_IM_ADDR_BIT'(10'h3F0);

    // Controller states (2-bit encoding).
    typedef enum logic [1:0] {
        ICC_IDLE    = 2'd0,
        ICC_ENTER   = 2'd1,
        ICC_SERVICE = 2'd2,
        ICC_RETURN  = 2'd3
    } icc_state_e;

endpackage

// File: rtl/intr_context_ctrl_epc.sv
// intr_epc_stack: LIFO of saved resume PCs (EPCs).
//   clk, rst_n   : clock, async active-low reset
//   push         : store push_data on top (ignored when full)
//   pop          : drop the top entry (ignored when empty)
//   push_data    : PC to save
//   top_c        : current top entry (0 when empty), combinational
//   full_c       : stack holds DEPTH entries, combinational
//   empty_c      : stack holds no entries, combinational
module intr_epc_stack
    import intr_context_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned AW    = CORE_IM_ADDR_BIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_c,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [DW-1:0] depth;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx  = IW'(depth);
    assign rd_idx  = IW'(depth - DW'(1));
    assign full_c  = (depth == DW'(DEPTH));
    assign empty_c = (depth == '0);
    assign top_c   = empty_c ? '0 : mem[rd_idx];

    // Push and pop never coincide in the controller; push takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full_c) begin
            mem[wr_idx] <= push_data;
            depth       <= depth + DW'(1);
        end else if (pop && !empty_c) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/intr_context_ctrl.sv
// intr_context_ctrl: saves the resume PC on interrupt entry, redirects and
// flushes fetch to the vector, gates interrupts while in service and runs
// the ERET return sequence.
// Optional nesting: define INTR_NEST_EN to turn the EPC into a NEST_DEPTH
// deep stack that software re-enables with ie_set; otherwise one EPC slot.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   intr_jmp          : pending unmasked interrupt from the interrupt device
//   intr_jmp_addr     : vector word address
//   pc_resume         : PC the interrupted program resumes at
//   pipe_safe         : pipeline may be redirected this cycle
//   eret              : ERET committing this cycle
//   ie_set            : interrupt-enable instruction committing (nesting)
//   intr_en           : global interrupt enable to the device
//   eret_clear_en     : 1-cycle pulse, device clears the serviced request
//   pc_redirect       : 1-cycle pulse, PC-select takes pc_redirect_addr
//   pc_redirect_addr  : redirect target
//   flush             : 1-cycle pulse, squash IF/ID/EX
//   in_service        : at least one interrupt in service
//   spurious_eret     : sticky, ERET seen with nothing in service
module intr_context_ctrl
    import intr_context_ctrl_pkg::*;
#(
    parameter int unsigned IM_ADDR_BIT = CORE_IM_ADDR_BIT,
    parameter int unsigned NEST_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   intr_jmp,
    input  logic [IM_ADDR_BIT-1:0] intr_jmp_addr,
    input  logic [IM_ADDR_BIT-1:0] pc_resume,
    input  logic                   pipe_safe,
    input  logic                   eret,
    input  logic                   ie_set,
    output logic                   intr_en,
    output logic                   eret_clear_en,
    output logic                   pc_redirect,
    output logic [IM_ADDR_BIT-1:0] pc_redirect_addr,
    output logic                   flush,
    output logic                   in_service,
    output logic                   spurious_eret
);

`ifdef INTR_NEST_EN
    localparam int unsigned STACK_DEPTH = NEST_DEPTH;
`else
    // Nesting off: a single EPC slot (NEST_DEPTH is assumed >= 1).
    localparam int unsigned STACK_DEPTH = (NEST_DEPTH > 1) ? 1 : NEST_DEPTH;
`endif

    icc_state_e             state;
    logic                   accept_c;
    logic                   push_c;
    logic                   pop_c;
    logic [IM_ADDR_BIT-1:0] epc_top_c;
    logic                   stk_full_c;
    logic                   stk_empty_c;

    assign accept_c = intr_jmp && intr_en && pipe_safe;
    // ERET wins over a same-edge accept in SERVICE; a full stack blocks nesting.
    assign push_c   = accept_c && ((state == ICC_IDLE) ||
                                   ((state == ICC_SERVICE) && !eret && !stk_full_c));
    assign pop_c    = (state == ICC_SERVICE) && eret;

    intr_epc_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (IM_ADDR_BIT)
    ) u_epc_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (pc_resume),
        .top_c     (epc_top_c),
        .full_c    (stk_full_c),
        .empty_c   (stk_empty_c)
    );

    // Controller FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ICC_IDLE;
            intr_en          <= 1'b1;
            eret_clear_en    <= 1'b0;
            pc_redirect      <= 1'b0;
            pc_redirect_addr <= '0;
            flush            <= 1'b0;
            in_service       <= 1'b0;
            spurious_eret    <= 1'b0;
        end else begin
            pc_redirect   <= 1'b0;
            flush         <= 1'b0;
            eret_clear_en <= 1'b0;
            unique case (state)
                ICC_IDLE: begin
                    if (eret) begin
                        spurious_eret <= 1'b1;
                    end
                    if (push_c) begin
                        state            <= ICC_ENTER;
                        intr_en          <= 1'b0;
                        pc_redirect      <= 1'b1;
                        flush            <= 1'b1;
                        pc_redirect_addr <= intr_jmp_addr;
                        in_service       <= 1'b1;
                    end
                end
                ICC_ENTER: begin
                    if (eret) begin
                        spurious_eret <= 1'b1;
                    end
                    state <= ICC_SERVICE;
                end
                ICC_SERVICE: begin
                    if (pop_c) begin
                        state            <= ICC_RETURN;
                        intr_en          <= 1'b0;
                        pc_redirect      <= 1'b1;
                        flush            <= 1'b1;
                        eret_clear_en    <= 1'b1;
                        pc_redirect_addr <= epc_top_c;
                    end else if (push_c) begin
                        state            <= ICC_ENTER;
                        intr_en          <= 1'b0;
                        pc_redirect      <= 1'b1;
                        flush            <= 1'b1;
                        pc_redirect_addr <= intr_jmp_addr;
                    end else if (stk_full_c) begin
                        intr_en <= 1'b0;
                    end else if (ie_set) begin
                        intr_en <= 1'b1;
                    end
                end
                ICC_RETURN: begin
                    // Enable rises a cycle after eret_clear_en so the device
                    // has already retired the serviced request.
                    intr_en <= 1'b1;
                    if (stk_empty_c) begin
                        state      <= ICC_IDLE;
                        in_service <= 1'b0;
                    end else begin
                        state <= ICC_SERVICE;
                    end
                end
                default: state <= ICC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_context_ctrl.sv
// Directed bench for intr_context_ctrl: entry, held-off entry, return,
// spurious ERET, simultaneous ERET/interrupt, reset mid-entry and (with
// INTR_NEST_EN) two-level nesting.
module tb_intr_context_ctrl;

    localparam int unsigned AW = 10;
`ifdef INTR_NEST_EN
    localparam int unsigned ND = 2;
`else
    localparam int unsigned ND = 4;
`endif

    logic          clk;
    logic          rst_n;
    logic          intr_jmp;
    logic [AW-1:0] intr_jmp_addr;
    logic [AW-1:0] pc_resume;
    logic          pipe_safe;
    logic          eret;
    logic          ie_set;
    logic          intr_en;
    logic          eret_clear_en;
    logic          pc_redirect;
    logic [AW-1:0] pc_redirect_addr;
    logic          flush;
    logic          in_service;
    logic          spurious_eret;

    int n_tests;
    int n_fail;

    intr_context_ctrl #(
        .IM_ADDR_BIT (AW),
        .NEST_DEPTH  (ND)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .intr_jmp         (intr_jmp),
        .intr_jmp_addr    (intr_jmp_addr),
        .pc_resume        (pc_resume),
        .pipe_safe        (pipe_safe),
        .eret             (eret),
        .ie_set           (ie_set),
        .intr_en          (intr_en),
        .eret_clear_en    (eret_clear_en),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .flush            (flush),
        .in_service       (in_service),
        .spurious_eret    (spurious_eret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Output snapshot: redirect, flush, clear, intr_en, in_service.
    task automatic chk_ctl(input string tag, input logic rd, input logic fl,
                           input logic clr, input logic ie, input logic ins);
        chk({tag, ".pc_redirect"},   32'(pc_redirect),   32'(rd));
        chk({tag, ".flush"},         32'(flush),         32'(fl));
        chk({tag, ".eret_clear_en"}, 32'(eret_clear_en), 32'(clr));
        chk({tag, ".intr_en"},       32'(intr_en),       32'(ie));
        chk({tag, ".in_service"},    32'(in_service),    32'(ins));
    endtask

    // Accept an interrupt from IDLE/SERVICE: one edge to ENTER, one to SERVICE.
    task automatic enter(input string tag, input logic [AW-1:0] vec, input logic [AW-1:0] pc);
        intr_jmp      = 1'b1;
        intr_jmp_addr = vec;
        pc_resume     = pc;
        pipe_safe     = 1'b1;
        tick();
        chk_ctl({tag, ".enter"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk({tag, ".enter.addr"}, 32'(pc_redirect_addr), 32'(vec));
        intr_jmp = 1'b0;
        tick();
        chk_ctl({tag, ".service"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        intr_jmp      = 1'b0;
        intr_jmp_addr = '0;
        pc_resume     = '0;
        pipe_safe     = 1'b0;
        eret          = 1'b0;
        ie_set        = 1'b0;

        // Reset values
        tick();
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.addr", 32'(pc_redirect_addr), 32'h0);
        chk("rst.spurious", 32'(spurious_eret), 32'h0);
        rst_n = 1'b1;
        tick();

        // Case 1: accept and redirect to 0x3F0
        enter("c1", 10'h3F0, 10'h040);

        // Case 3: ERET returns to 0x040, intr_en rises one cycle later
        eret = 1'b1;
        tick();
        chk_ctl("c3.ret", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("c3.ret.addr", 32'(pc_redirect_addr), 32'h040);
        eret = 1'b0;
        tick();
        chk_ctl("c3.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("c3.spurious", 32'(spurious_eret), 32'h0);

        // Case 2: held off by pipe_safe for 3 cycles
        intr_jmp      = 1'b1;
        intr_jmp_addr = 10'h2A0;
        pc_resume     = 10'h111;
        pipe_safe     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("c2.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        pipe_safe = 1'b1;
        pc_resume = 10'h155;
        tick();
        chk_ctl("c2.enter", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("c2.enter.addr", 32'(pc_redirect_addr), 32'h2A0);
        intr_jmp  = 1'b0;
        pc_resume = 10'h1FF;
        tick();
        chk_ctl("c2.service", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eret = 1'b1;
        tick();
        chk("c2.epc", 32'(pc_redirect_addr), 32'h155);
        chk("c2.clear", 32'(eret_clear_en), 32'h1);
        eret = 1'b0;
        tick();
        chk_ctl("c2.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ERET and intr_jmp together in SERVICE: ERET wins
        enter("sim", 10'h300, 10'h0AA);
        eret          = 1'b1;
        intr_jmp      = 1'b1;
        intr_jmp_addr = 10'h3C0;
        tick();
        chk("sim.addr", 32'(pc_redirect_addr), 32'h0AA);
        chk("sim.clear", 32'(eret_clear_en), 32'h1);
        eret     = 1'b0;
        intr_jmp = 1'b0;
        tick();
        chk_ctl("sim.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Case 4: ERET in IDLE is spurious and sticky
        eret = 1'b1;
        tick();
        chk("c4.redirect", 32'(pc_redirect), 32'h0);
        chk("c4.spurious", 32'(spurious_eret), 32'h1);
        eret = 1'b0;
        tick();
        tick();
        chk("c4.sticky", 32'(spurious_eret), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("c4.rst_clear", 32'(spurious_eret), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // ERET during ENTER is spurious
        intr_jmp      = 1'b1;
        intr_jmp_addr = 10'h380;
        pc_resume     = 10'h022;
        tick();
        intr_jmp = 1'b0;
        eret     = 1'b1;
        tick();
        eret = 1'b0;
        chk("enter_eret.spurious", 32'(spurious_eret), 32'h1);
        chk_ctl("enter_eret.service", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eret = 1'b1;
        tick();
        chk("enter_eret.ret.addr", 32'(pc_redirect_addr), 32'h022);
        eret = 1'b0;
        tick();

        // Case 6: reset during ENTER abandons everything asynchronously
        intr_jmp      = 1'b1;
        intr_jmp_addr = 10'h3F0;
        pc_resume     = 10'h077;
        tick();
        chk("c6.enter", 32'(pc_redirect), 32'h1);
        intr_jmp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("c6.async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("c6.addr", 32'(pc_redirect_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("c6.quiet", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

`ifdef INTR_NEST_EN
        // Case 5: two-level nesting with NEST_DEPTH = 2
        enter("c5.outer", 10'h3F0, 10'h040);
        ie_set = 1'b1;
        tick();
        ie_set = 1'b0;
        chk("c5.ie_set", 32'(intr_en), 32'h1);
        enter("c5.inner", 10'h3E0, 10'h100);
        ie_set = 1'b1;
        tick();
        ie_set = 1'b0;
        chk("c5.full_ignore", 32'(intr_en), 32'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("c5.ret1.addr", 32'(pc_redirect_addr), 32'h100);
        chk("c5.ret1.clear", 32'(eret_clear_en), 32'h1);
        tick();
        chk_ctl("c5.back_service", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("c5.ret2.addr", 32'(pc_redirect_addr), 32'h040);
        tick();
        chk_ctl("c5.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        // Without nesting ie_set and further interrupts are ignored in SERVICE
        enter("nonest", 10'h3F0, 10'h040);
        ie_set        = 1'b1;
        intr_jmp      = 1'b1;
        intr_jmp_addr = 10'h3E0;
        tick();
        ie_set   = 1'b0;
        intr_jmp = 1'b0;
        chk_ctl("nonest.ignore", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("nonest.ret.addr", 32'(pc_redirect_addr), 32'h040);
        tick();
        chk_ctl("nonest.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
